rr_arbiter8: RTL



---
 rtl/rr_arbiter8.sv | 81 ++++++++
 1 files changed

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with held, registered one-hot grants.
// Define RR_ARB_TIMEOUT_EN to force-release grants held for TIMEOUT_CYC cycles.
module rr_arbiter8 #(
    parameter int N           = 8,
    parameter int PTR_W       = 3,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         release_i,
    output logic [N-1:0] grant,
    output logic         grant_valid,
    output logic         timeout
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d, owner_q, owner_d, sel;
    logic [N-1:0]       grant_q, grant_d;
    logic               grant_valid_q;
    logic               hit, done;
`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;
    assign hit       = state_q == BUSY && cnt_q == 8'(TIMEOUT_CYC - 1);
    assign cnt_d     = state_q == BUSY ? cnt_q + 8'd1 : 8'd0;
    assign timeout_d = hit && !release_i && req[owner_q];
    assign timeout   = timeout_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
`else
    logic unused_tc;
    assign unused_tc = ^TIMEOUT_CYC;
    assign hit       = 1'b0;
    assign timeout   = 1'b0;
`endif
    assign done = release_i || !req[owner_q] || hit;
    always_comb begin
        sel = ptr_q;
        for (int k = N - 1; k >= 0; k--)
            if (req[ptr_q + PTR_W'(k)]) sel = ptr_q + PTR_W'(k);
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        if (state_q == IDLE && |req) begin
            state_d = BUSY;
            owner_d = sel;
            grant_d = N'(1) << sel;
        end else if (state_q == BUSY && done) begin
            // returning to IDLE forces the zero-grant gap before the next owner
            state_d = IDLE;
            ptr_d   = owner_q + PTR_W'(1);
            grant_d = '0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            owner_q       <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            grant_q       <= grant_d;
            grant_valid_q <= |grant_d;
        end
    end
    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
endmodule
